ft_cmd_sched: RTL and testbench
===============================

# ft_cmd_sched

Command parser and transmit scheduler between the FT245 bridge FIFOs and the rest of the camera logic. It pops host command bytes from the RX FIFO and turns them into register writes and register reads on a simple byte-wide register bus. It also arbitrates the TX FIFO between register-read responses and the 16-bit CCD pixel stream. It lives in the system clock domain on the far side of the dual-clock FIFOs.

## Interface
Parameters:
- `CMD_TIMEOUT`, default 1024: cycles the parser waits for a write-data byte before aborting.

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `rx_rempty`  in  1  RX FIFO empty. First-word-fall-through; `rx_rdata` is valid whenever this is low.
- `rx_rdata`  in  8  RX FIFO head byte.
- `rx_rinc`  out  1  pop RX FIFO. Only asserted while `rx_rempty` is 0.
- `tx_wfull`  in  1  TX FIFO full.
- `tx_wdata`  out  8  byte to TX FIFO.
- `tx_winc`  out  1  push TX FIFO. Only asserted while `tx_wfull` is 0.
- `reg_addr`  out  7  register address, held after every command.
- `reg_wdata`  out  8  register write data.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_rdata`  in  8  combinational read data for `reg_addr`.
- `pix_valid`  in  1  pixel available.
- `pix_data`  in  16  pixel value.
- `pix_ready`  out  1  pixel accepted when `pix_valid` and `pix_ready` are both high.
- `cmd_timeout`  out  1  one-cycle pulse on write-data timeout.

## Operation
- Command byte format: bit7 = 1 is a write, bit7 = 0 is a read; bits6:0 are the address.
- Parser FSM states: `P_IDLE`, `P_WDATA`, `P_RCAP`.
- `P_IDLE`:
  - Write command at the head with `!rx_rempty`: pop it, latch `reg_addr`, go to `P_WDATA`.
  - Read command: pop only if `rsp_pending` is 0. Latch `reg_addr`, go to `P_RCAP`. While a response is pending, the read stays unpopped at the head and the parser stalls.
- `P_WDATA`:
  - On `!rx_rempty`: pop, latch `reg_wdata`. `reg_we` is 1 in the next cycle. Return to `P_IDLE`.
  - If `CMD_TIMEOUT` consecutive cycles pass with no byte: pulse `cmd_timeout`, return to `P_IDLE`, no `reg_we`.
- `P_RCAP`: capture `rsp_data <= reg_rdata`, set `rsp_pending`, return to `P_IDLE`.
- TX FSM states: `T_IDLE`, `T_RSP_HDR`, `T_RSP_DAT`, `T_PIX_LO`, `T_PIX_HI`.
- `T_IDLE`:
  - If `rsp_pending`: go to `T_RSP_HDR`.
  - Else `pix_ready` = 1; on a handshake, latch the pixel and go to `T_PIX_LO`.
- `T_RSP_HDR`: write `{1'b1, reg_addr_latched}`.
- `T_RSP_DAT`: write `rsp_data`, clear `rsp_pending`, go to `T_IDLE`.
- `T_PIX_LO`: write `pix[7:0]`. `T_PIX_HI`: write `pix[15:8]`, go to `T_IDLE`.
- Each write state advances only on a cycle where `tx_winc` fires. `tx_winc` = write-state & `!tx_wfull`, combinational.
- A pixel's two bytes are never split by a response. A response preempts the pixel stream only at pixel boundaries.

## Timing
- Reset values: all outputs 0; both FSMs idle; `rsp_pending` = 0; timeout counter = 0.
- Write command latency: `reg_we` is 1 exactly one cycle after the data-byte pop.
- Read command latency:
  - Pop, then capture one cycle later.
  - The header can write in the third cycle at the earliest.
  - Header and data are on consecutive cycles if the TX FIFO is not full.
- Pixel throughput: 2 bytes per 3 cycles when unstalled. `pix_ready` is low in `T_PIX_LO` and `T_PIX_HI`.
- Simultaneous events:
  - `pix_ready` is derived from registered `rsp_pending`. A pixel accepted in the same cycle `rsp_pending` rises completes first.
  - Write commands keep processing while a response is pending.
- Timeout counter:
  - Width `$clog2(CMD_TIMEOUT+1)`.
  - Cleared on entry to `P_WDATA`.
  - Increments while `rx_rempty` is high; does not wrap.
- Reset mid-operation: any partial pixel or response is dropped and nothing further is written. The host resynchronises.

## Structure
- Package `ft_cmd_pkg`: parser and TX state encodings, command bit positions (`CMD_WR_BIT` = 7, address field 6:0), response header rule.
- Sub-module `ft_tx_sched`: the TX FSM, pixel latch and byte mux. The parser and timeout stay in the top level.

## Test plan
- Write path: RX bytes 0x85, 0x3C → `reg_addr` = 0x05, `reg_wdata` = 0x3C, `reg_we` high for one cycle, no `tx_winc`.
- Read path: RX 0x12 with `reg_rdata` = 0x77 → TX bytes 0x92, 0x77.
- Pixel stream: pixels 0xBEEF, 0x1234 → TX bytes 0xEF, 0xBE, 0x34, 0x12; `pix_ready` low during byte emission.
- Preemption: read 0x12 arrives while 0xBEEF is in `T_PIX_LO` → TX bytes 0xEF, 0xBE, 0x92, 0x77, then pixels resume.
- Backpressure: `tx_wfull` held for 20 cycles mid-pixel, then read-while-pending → `tx_winc` stays 0, byte order preserved, second read not popped until the first response's data byte is written.
- Timeout (`CMD_TIMEOUT` = 16): 0x85 then idle for 16 cycles → one `cmd_timeout` pulse, no `reg_we`; the next byte 0x01 is parsed as a read (TX bytes 0x81, data).

Source files
------------

// File: rtl/ft_cmd_pkg.sv
// Shared encodings for the FT245 command parser and TX scheduler.
// No logic of its own; state codes, command field positions, response header rule.
// Backpressure: n/a.
package ft_cmd_pkg;

    localparam logic [1:0] P_IDLE  = 2'd0;
    localparam logic [1:0] P_WDATA = 2'd1;
    localparam logic [1:0] P_RCAP  = 2'd2;

    localparam logic [2:0] T_IDLE    = 3'd0;
    localparam logic [2:0] T_RSP_HDR = 3'd1;
    localparam logic [2:0] T_RSP_DAT = 3'd2;
    localparam logic [2:0] T_PIX_LO  = 3'd3;
    localparam logic [2:0] T_PIX_HI  = 3'd4;

    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

    typedef logic [CMD_ADDR_MSB:0] reg_addr_t;

    // The host tells responses apart from the address echo by bit7 set.
    function automatic logic [7:0] rsp_hdr(input reg_addr_t addr);
        return {1'b1, addr};
    endfunction

endpackage

// File: rtl/ft_tx_sched.sv
// TX FIFO arbiter: register-read responses (hdr+data) vs 16-bit pixels (lo, hi).
// Latency: pixel accepted in T_IDLE, bytes on the next two write cycles; 3 cycles/pixel unstalled.
// Backpressure: each write state holds while tx_wfull; responses only preempt at pixel boundaries.
module ft_tx_sched
    import ft_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run_i,
    input  logic        rsp_pending_i,
    input  logic [7:0]  rsp_hdr_i,
    input  logic [7:0]  rsp_data_i,
    input  logic        tx_wfull_i,
    input  logic        pix_valid_i,
    input  logic [15:0] pix_data_i,
    output logic        tx_winc_o,
    output logic [7:0]  tx_wdata_o,
    output logic        pix_ready_o,
    output logic        rsp_done_o
);

    logic [2:0]  state_q, state_d;
    logic [15:0] pix_q, pix_d;
    logic        wr_state;

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        wr_state    = 1'b0;
        tx_wdata_o  = 8'h00;
        pix_ready_o = 1'b0;
        rsp_done_o  = 1'b0;
        case (state_q)
            T_IDLE: begin
                if (rsp_pending_i) begin
                    state_d = T_RSP_HDR;
                end else begin
                    pix_ready_o = run_i;
                    if (run_i && pix_valid_i) begin
                        pix_d   = pix_data_i;
                        state_d = T_PIX_LO;
                    end
                end
            end
            T_RSP_HDR: begin
                wr_state   = 1'b1;
                tx_wdata_o = rsp_hdr_i;
                if (!tx_wfull_i) state_d = T_RSP_DAT;
            end
            T_RSP_DAT: begin
                wr_state   = 1'b1;
                tx_wdata_o = rsp_data_i;
                if (!tx_wfull_i) begin
                    rsp_done_o = 1'b1;
                    state_d    = T_IDLE;
                end
            end
            T_PIX_LO: begin
                wr_state   = 1'b1;
                tx_wdata_o = pix_q[7:0];
                if (!tx_wfull_i) state_d = T_PIX_HI;
            end
            T_PIX_HI: begin
                wr_state   = 1'b1;
                tx_wdata_o = pix_q[15:8];
                if (!tx_wfull_i) state_d = T_IDLE;
            end
            default: state_d = T_IDLE;
        endcase
    end

    assign tx_winc_o = wr_state & ~tx_wfull_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T_IDLE;
            pix_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
        end
    end

endmodule

// File: rtl/ft_cmd_sched.sv
// Host command parser (RX FIFO -> register bus) plus TX scheduler for responses and pixels.
// Latency: reg_we one cycle after data pop; read header three cycles after command pop.
// Backpressure: reads stall unpopped while a response is pending; write-data wait bounded by CMD_TIMEOUT.
module ft_cmd_sched
    import ft_cmd_pkg::*;
#(
    parameter int CMD_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rempty,
    input  logic [7:0]  rx_rdata,
    output logic        rx_rinc,
    input  logic        tx_wfull,
    output logic [7:0]  tx_wdata,
    output logic        tx_winc,
    output logic [6:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    input  logic [7:0]  reg_rdata,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        cmd_timeout
);

    localparam int TW = $clog2(CMD_TIMEOUT + 1);

    logic [1:0]   p_state_q, p_state_d;
    reg_addr_t    addr_q, addr_d;
    logic [7:0]   wdata_q, wdata_d;
    logic         we_q, we_d;
    logic         tmo_q, tmo_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic         rsp_pending_q, rsp_pending_d;
    logic [7:0]   rsp_data_q, rsp_data_d;
    reg_addr_t    rsp_addr_q, rsp_addr_d;
    logic         run_q;
    logic         rsp_set, rsp_done;

    always_comb begin
        p_state_d  = p_state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        tmo_d      = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_addr_d = rsp_addr_q;
        rsp_set    = 1'b0;
        rx_rinc    = 1'b0;
        case (p_state_q)
            P_IDLE: begin
                if (run_q && !rx_rempty) begin
                    if (rx_rdata[CMD_WR_BIT]) begin
                        rx_rinc   = 1'b1;
                        addr_d    = rx_rdata[CMD_ADDR_MSB:0];
                        tmo_cnt_d = '0;
                        p_state_d = P_WDATA;
                    end else if (!rsp_pending_q) begin
                        rx_rinc   = 1'b1;
                        addr_d    = rx_rdata[CMD_ADDR_MSB:0];
                        p_state_d = P_RCAP;
                    end
                end
            end
            P_WDATA: begin
                if (!rx_rempty) begin
                    rx_rinc   = 1'b1;
                    wdata_d   = rx_rdata;
                    we_d      = 1'b1;
                    p_state_d = P_IDLE;
                end else begin
                    if (tmo_cnt_q != TW'(CMD_TIMEOUT)) tmo_cnt_d = tmo_cnt_q + TW'(1);
                    // This empty cycle is the CMD_TIMEOUT-th in a row.
                    if (tmo_cnt_q == TW'(CMD_TIMEOUT - 1)) begin
                        tmo_d     = 1'b1;
                        p_state_d = P_IDLE;
                    end
                end
            end
            P_RCAP: begin
                rsp_data_d = reg_rdata;
                rsp_addr_d = addr_q;
                rsp_set    = 1'b1;
                p_state_d  = P_IDLE;
            end
            default: p_state_d = P_IDLE;
        endcase
        rsp_pending_d = (rsp_pending_q & ~rsp_done) | rsp_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state_q     <= P_IDLE;
            addr_q        <= '0;
            wdata_q       <= 8'h00;
            we_q          <= 1'b0;
            tmo_q         <= 1'b0;
            tmo_cnt_q     <= '0;
            rsp_pending_q <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_addr_q    <= '0;
            run_q         <= 1'b0;
        end else begin
            p_state_q     <= p_state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            tmo_q         <= tmo_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
            run_q         <= 1'b1;
        end
    end

    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign reg_we      = we_q;
    assign cmd_timeout = tmo_q;

    // Header uses the address captured with the response; reg_addr may move on with later writes.
    ft_tx_sched u_tx (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run_q),
        .rsp_pending_i (rsp_pending_q),
        .rsp_hdr_i     (rsp_hdr(rsp_addr_q)),
        .rsp_data_i    (rsp_data_q),
        .tx_wfull_i    (tx_wfull),
        .pix_valid_i   (pix_valid),
        .pix_data_i    (pix_data),
        .tx_winc_o     (tx_winc),
        .tx_wdata_o    (tx_wdata),
        .pix_ready_o   (pix_ready),
        .rsp_done_o    (rsp_done)
    );

endmodule

// File: tb/tb_ft_cmd_sched.sv
// Directed bench for ft_cmd_sched: FIFO/pixel source models, stream-level scoreboard, literal byte logs.
module tb_ft_cmd_sched;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rempty, rx_rinc, tx_wfull, tx_winc, reg_we;
    logic        pix_valid, pix_ready, cmd_timeout;
    logic [7:0]  rx_rdata, tx_wdata, reg_wdata, reg_rdata;
    logic [6:0]  reg_addr;
    logic [15:0] pix_data;

    always #5 clk = ~clk;

    // Register file contents: value = address + 0x65 (0x12 -> 0x77).
    assign reg_rdata = {1'b0, reg_addr} + 8'h65;

    ft_cmd_sched #(.CMD_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .rx_rempty(rx_rempty), .rx_rdata(rx_rdata), .rx_rinc(rx_rinc),
        .tx_wfull(tx_wfull), .tx_wdata(tx_wdata), .tx_winc(tx_winc),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .cmd_timeout(cmd_timeout)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  rxq[$];
    logic [15:0] pixq[$];
    logic [7:0]  exp_rsp[$];
    logic [7:0]  exp_pix[$];
    logic [14:0] exp_wr[$];
    logic [7:0]  log_b[$];
    int          log_c[$];
    logic [7:0]  lit[$];

    int rx_pops_seen = 0, rx_pops_done = 0;
    int pix_pops_seen = 0, pix_pops_done = 0;
    int cyc = 0, we_cnt = 0, tmo_cnt = 0;
    int last_rpop = 0, last_hdr = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        rx_rempty = (rxq.size() == 0);
        rx_rdata  = (rxq.size() != 0) ? rxq[0] : 8'h00;
        pix_valid = (pixq.size() != 0);
        pix_data  = (pixq.size() != 0) ? pixq[0] : 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        while (rx_pops_done < rx_pops_seen) begin
            if (rxq.size() != 0) void'(rxq.pop_front());
            rx_pops_done++;
        end
        while (pix_pops_done < pix_pops_seen) begin
            if (pixq.size() != 0) void'(pixq.pop_front());
            pix_pops_done++;
        end
        drive();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        rxq.push_back({1'b1, a});
        rxq.push_back(d);
        exp_wr.push_back({a, d});
        drive();
    endtask

    task automatic do_read(input logic [6:0] a);
        rxq.push_back({1'b0, a});
        exp_rsp.push_back({1'b1, a});
        exp_rsp.push_back({1'b0, a} + 8'h65);
        drive();
    endtask

    task automatic do_pix(input logic [15:0] p);
        pixq.push_back(p);
        exp_pix.push_back(p[7:0]);
        exp_pix.push_back(p[15:8]);
        drive();
    endtask

    task automatic check_log(input string nm);
        check({nm, "_len"}, log_b.size(), lit.size());
        for (int i = 0; i < lit.size() && i < log_b.size(); i++)
            check(nm, log_b[i], lit[i]);
    endtask

    // Stream-level scoreboard, sampled on the falling edge.
    initial begin : compare
        bit waiting = 1'b0, we_exp = 1'b0, tmo_exp = 1'b0;
        bit pix_hi_due = 1'b0, rsp_dat_due = 1'b0;
        int wait_run = 0, pix_acc = 0, outstanding = 0;
        forever begin
            @(negedge clk);
            if (started && !rst) begin
                cyc++;
                check("rinc_while_empty", rx_rinc & rx_rempty, 1'b0);
                check("winc_while_full", tx_winc & tx_wfull, 1'b0);
                check("reg_we", reg_we, we_exp);
                check("cmd_timeout", cmd_timeout, tmo_exp);
                if (reg_we) begin
                    we_cnt++;
                    if (exp_wr.size() == 0) check("wr_extra", 1, 0);
                    else check("wr_addr_data", {reg_addr, reg_wdata}, exp_wr.pop_front());
                end
                if (cmd_timeout) tmo_cnt++;
                we_exp  = 1'b0;
                tmo_exp = 1'b0;
                if (pix_ready)
                    check("pix_ready_busy", (pix_acc != 0) || pix_hi_due || rsp_dat_due, 1'b0);
                if (waiting && rx_rempty) begin
                    wait_run++;
                    if (wait_run == TMO) begin
                        tmo_exp = 1'b1;
                        waiting = 1'b0;
                    end
                end else if (waiting) begin
                    check("wdata_pop", rx_rinc, 1'b1);
                end
                if (rx_rinc) begin
                    rx_pops_seen++;
                    if (waiting) begin
                        we_exp  = 1'b1;
                        waiting = 1'b0;
                    end else if (rx_rdata[7]) begin
                        waiting  = 1'b1;
                        wait_run = 0;
                    end else begin
                        check("read_while_pending", outstanding, 0);
                        outstanding++;
                        last_rpop = cyc;
                    end
                end
                if (tx_winc) begin
                    log_b.push_back(tx_wdata);
                    log_c.push_back(cyc);
                    if (pix_hi_due || (!rsp_dat_due && pix_acc > 0)) begin
                        if (exp_pix.size() == 0) check("tx_pix_extra", 1, 0);
                        else check("tx_pix_byte", tx_wdata, exp_pix.pop_front());
                        if (pix_hi_due) pix_hi_due = 1'b0;
                        else begin pix_acc--; pix_hi_due = 1'b1; end
                    end else begin
                        if (exp_rsp.size() == 0) check("tx_rsp_extra", 1, 0);
                        else check("tx_rsp_byte", tx_wdata, exp_rsp.pop_front());
                        if (rsp_dat_due) begin
                            rsp_dat_due = 1'b0;
                            outstanding--;
                        end else begin
                            rsp_dat_due = 1'b1;
                            last_hdr    = cyc;
                        end
                    end
                end
                if (pix_valid && pix_ready) begin
                    pix_pops_seen++;
                    pix_acc++;
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        tx_wfull = 1'b0;
        // Non-empty inputs during reset: nothing may be popped or accepted.
        rx_rempty = 1'b0;
        rx_rdata  = 8'h12;
        pix_valid = 1'b1;
        pix_data  = 16'h5555;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_rinc", rx_rinc, 1'b0);
        check("rst_tx_winc", tx_winc, 1'b0);
        check("rst_tx_wdata", tx_wdata, 8'h00);
        check("rst_reg_addr", reg_addr, 7'h00);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_reg_we", reg_we, 1'b0);
        check("rst_pix_ready", pix_ready, 1'b0);
        check("rst_cmd_timeout", cmd_timeout, 1'b0);
        @(posedge clk);
        #1;
        drive();
        rst = 1'b0;
        started = 1'b1;
        ticks(3);

        // Write path
        do_write(7'h05, 8'h3C);
        ticks(6);
        check("wr_reg_addr", reg_addr, 7'h05);
        check("wr_reg_wdata", reg_wdata, 8'h3C);
        check("wr_we_count", we_cnt, 1);
        check("wr_no_tx", log_b.size(), 0);

        // Read path
        do_read(7'h12);
        ticks(8);
        lit = '{8'h92, 8'h77};
        check_log("rd_bytes");
        check("rd_hdr_latency", last_hdr - last_rpop, 3);
        check("rd_dat_follows", log_c[1] - log_c[0], 1);
        log_b.delete(); log_c.delete();

        // Pixel stream
        do_pix(16'hBEEF);
        do_pix(16'h1234);
        ticks(10);
        lit = '{8'hEF, 8'hBE, 8'h34, 8'h12};
        check_log("pix_bytes");
        check("pix_period", log_c[2] - log_c[0], 3);
        log_b.delete(); log_c.delete();

        // Read arrives while the first pixel is in its low-byte state
        do_pix(16'hBEEF);
        do_pix(16'h1234);
        tick();
        do_read(7'h12);
        ticks(12);
        lit = '{8'hEF, 8'hBE, 8'h92, 8'h77, 8'h34, 8'h12};
        check_log("preempt_bytes");
        log_b.delete(); log_c.delete();

        // Backpressure mid-pixel, then a second read queued behind a pending response
        do_pix(16'hA1B2);
        ticks(2);
        tx_wfull = 1'b1;
        do_read(7'h21);
        do_read(7'h33);
        do_pix(16'hC3D4);
        ticks(20);
        check("bp_bytes_during_full", log_b.size(), 1);
        check("bp_second_read_held", rxq.size(), 1);
        tx_wfull = 1'b0;
        ticks(30);
        lit = '{8'hB2, 8'hA1, 8'hA1, 8'h86, 8'hD4, 8'hC3, 8'hB3, 8'h98};
        check_log("bp_bytes");
        log_b.delete(); log_c.delete();

        // Data byte on the last allowed cycle: still a write
        rxq.push_back(8'h9A);
        drive();
        ticks(16);
        rxq.push_back(8'h5A);
        exp_wr.push_back({7'h1A, 8'h5A});
        drive();
        ticks(5);
        check("late_wr_no_timeout", tmo_cnt, 0);
        check("late_wr_count", we_cnt, 2);
        check("late_wr_addr", reg_addr, 7'h1A);

        // Timeout, then next byte parsed as a fresh read
        rxq.push_back(8'h85);
        drive();
        ticks(17);
        do_read(7'h01);
        ticks(12);
        check("tmo_pulses", tmo_cnt, 1);
        check("tmo_no_we", we_cnt, 2);
        lit = '{8'h81, 8'h66};
        check_log("tmo_rd_bytes");

        check("end_rsp_left", exp_rsp.size(), 0);
        check("end_pix_left", exp_pix.size(), 0);
        check("end_wr_left", exp_wr.size(), 0);
        check("end_rx_left", rxq.size(), 0);
        check("end_pixq_left", pixq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
